led_pulse_arb: RTL and testbench
================================

// Module: led_pulse_arb
// PURPOSE
//  Shares one LED pulse timer between NREQ trigger sources.
//  - Each source's rising edge queues a request. A round-robin arbiter grants one request at a time.
//  - The granted request drives a fixed-length, active-low LED pulse, followed by a mandatory dark gap.
//  - Sits between the CPU/debug event strobes and the board LED, so no event is lost when events overlap.
// PARAMETERS
//  NREQ        4        number of trigger sources (2..8)
//  PULSE_TIME  3500000  pulse length index; LED is lit PULSE_TIME+1 cycles
//  GAP_TIME    350000   dark cycles between consecutive pulses; 0 = no gap
//  CW          24       timer width; elaboration error if max(PULSE_TIME,GAP_TIME) >= 2**CW
// PORTS
//  clk       in   1              system clock; all logic is on posedge
//  rst       in   1              synchronous, active-high reset
//  trigx     in   NREQ           trigger strobes; synchronous to clk; edge-detected per bit
//  led       out  1              active-low LED drive; 0 = lit
//  grant_id  out  $clog2(NREQ)   index of the source currently served; valid while busy=1
//  busy      out  1              1 in PULSE or GAP
//  pend      out  NREQ           pending-request flags (registered)
// BEHAVIOUR
//  Reset values (rst=1 at a posedge):
//   - led=1, busy=0, grant_id=0, pend=0, trig_q=0, state=IDLE, timer=0
//   - last_grant=NREQ-1, so source 0 has first priority
//  Edge detect:
//   - rise = trigx & ~trig_q; trig_q <= trigx every cycle.
//   - A level held high queues exactly one request.
//  Pending flags:
//   - pend <= (pend & ~clr) | rise. Set wins over the grant clear in the same cycle (re-queue).
//  Arbiter:
//   - Search pend starting at last_grant+1, wrapping modulo NREQ. First set bit wins.
//   - Winner: grant_id <= win, last_grant <= win, its pend bit cleared.
//  State machine:
//   - IDLE:
//     - pend==0: stay; led=1, busy=0.
//     - pend!=0: grant; -> PULSE, timer=0, led<=0, busy<=1.
//   - PULSE:
//     - timer increments each cycle.
//     - At timer==PULSE_TIME: timer<=0, led<=1.
//       - GAP_TIME>0: -> GAP.
//       - GAP_TIME==0 and pend!=0: grant immediately; -> PULSE, led stays 0 for that cycle.
//       - GAP_TIME==0 and pend==0: -> IDLE.
//   - GAP:
//     - led=1; timer increments.
//     - At timer==GAP_TIME-1: timer<=0.
//       - pend!=0: grant; -> PULSE, led<=0.
//       - pend==0: -> IDLE, busy<=0.
//  Latency:
//   - trigx rises before edge k -> pend set after edge k -> grant, led=0 and busy=1 after edge k+1.
//   - Total: 2 cycles from IDLE.
//  Timing: LED lit exactly PULSE_TIME+1 cycles; dark gap exactly GAP_TIME cycles.
//  Simultaneous edges: all bits queue; served in round-robin order.
//  Overflow: a rise on an already-pending bit is absorbed; there is no counting.
//  Reset mid-operation: aborts immediately to the reset values; queued requests are discarded.
// CONFIGURATION
//  LED_ARB_RETRIG_EN
//   - Defined: in PULSE, a rise on trigx[grant_id] restarts timer to 0, extending the pulse,
//     and does NOT set pend[grant_id]. This gives monostable retrigger semantics for the active source.
//   - Undefined: that rise sets pend[grant_id] like any other rise, so a second pulse is served later.
// STRUCTURE
//  Package led_arb_pkg:
//   - typedef enum logic[1:0] {IDLE, PULSE, GAP} arb_state_t
//   - function rr_pick(pend, last) returning the winner index
//  Sub-module led_pulse_timer:
//   - CW-bit counter with inputs clr/en and a terminal-count compare (tc_pulse, tc_gap)
//   - Instanced once; FSM and arbiter stay in the top module
// TESTING (PULSE_TIME=10, GAP_TIME=3, NREQ=4 unless noted)
//  1. Single request:
//     - trigx[1] 1-cycle strobe -> led=0 from 2 cycles later for 11 cycles, grant_id=1;
//     - then GAP 3 cycles, then IDLE with busy=0.
//  2. Simultaneous edges:
//     - trigx=4'b0101 in one cycle -> pulses for id 0 then id 2; 3 dark cycles between; pend=0 at end.
//  3. Fairness:
//     - all four strobed while id 2 is active -> service order 3,0,1,2;
//     - a level held high on trigx[0] yields only one pulse.
//  4. Re-queue at grant:
//     - rise on a bit in the same cycle as its grant -> pend bit stays 1; a second pulse is served.
//  5. Reset mid-pulse:
//     - rst at timer=5 -> next cycle led=1, busy=0, pend=0.
//     - A new strobe is served with source 0 first priority.
//  6. Build variants:
//     - RETRIG_EN defined: restrobe id 1 at timer=8 -> pulse lasts 8+11=19 cycles.
//     - RETRIG_EN undefined: two pulses instead.
//     - GAP_TIME=0: back-to-back pulses with no dark cycle.

Source files
------------

// File: rtl/led_arb_pkg.sv
// Shared types and the round-robin pick helper for the LED pulse arbiter.
package led_arb_pkg;

  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned MAX_IW   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // First set bit of pend searching upward from last+1, wrapping modulo nreq.
  function automatic logic [MAX_IW-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] pend,
    input logic [MAX_IW-1:0]   last,
    input int unsigned         nreq
  );
    logic [MAX_IW-1:0] win;
    logic              found;
    int unsigned       idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_NREQ; i++) begin
      idx = (32'(last) + i) % nreq;
      if ((i <= nreq) && !found && pend[idx[MAX_IW-1:0]]) begin
        win   = idx[MAX_IW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/led_pulse_timer.sv
// Shared pulse/gap timer: CW-bit up-counter with clear/enable and the two
// terminal-count compares used by the arbiter FSM.
module led_pulse_timer #(
  parameter int unsigned CW         = 24,
  parameter int unsigned PULSE_TIME = 3500000,
  parameter int unsigned GAP_TIME   = 350000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc_pulse_c,
  output logic tc_gap_c
);

  localparam logic [CW-1:0] PULSE_TC = CW'(PULSE_TIME);
  // Gap ends one count early so the dark phase lasts exactly GAP_TIME cycles.
  localparam logic [CW-1:0] GAP_TC   = (GAP_TIME == 0) ? '0 : CW'(GAP_TIME - 32'd1);

  logic [CW-1:0] count;

  // Counter: clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  // Terminal-count compares.
  always_comb begin
    tc_pulse_c = (count == PULSE_TC);
    tc_gap_c   = (count == GAP_TC);
  end

endmodule

// File: rtl/led_pulse_arb.sv
// Round-robin arbiter sharing one LED pulse timer between NREQ trigger sources.
// Each trigger rising edge queues one request; each grant produces a lit pulse
// of PULSE_TIME+1 cycles followed by GAP_TIME dark cycles.
// Build option: LED_ARB_RETRIG_EN -- a rise on the active source during its
// pulse restarts the pulse instead of queueing another one.
module led_pulse_arb
  import led_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned PULSE_TIME = 3500000,
  parameter int unsigned GAP_TIME   = 350000,
  parameter int unsigned CW         = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         trigx,
  output logic                    led,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [NREQ-1:0]         pend
);

  localparam int unsigned     IW   = $clog2(NREQ);
  localparam longint unsigned TMAX = (PULSE_TIME > GAP_TIME) ? 64'(PULSE_TIME) : 64'(GAP_TIME);

  if ((NREQ < 2) || (NREQ > MAX_NREQ)) begin : g_bad_nreq
    $error("led_pulse_arb: NREQ must be in 2..8");
  end
  if ((CW < 64) && (TMAX >= (64'd1 << CW))) begin : g_bad_cw
    $error("led_pulse_arb: PULSE_TIME/GAP_TIME do not fit in CW bits");
  end

  arb_state_t      state, state_n;
  logic            led_n, busy_n, do_grant, any_pend;
  logic [IW-1:0]   gid_n, last_grant, last_n, win;
  logic [NREQ-1:0] trig_q, rise, rise_eff, clr, pend_n;
  logic            tmr_clr, tmr_en, tc_pulse_c, tc_gap_c;
`ifdef LED_ARB_RETRIG_EN
  logic            retrig;
`endif

  led_pulse_timer #(
    .CW         (CW),
    .PULSE_TIME (PULSE_TIME),
    .GAP_TIME   (GAP_TIME)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr        (tmr_clr),
    .en         (tmr_en),
    .tc_pulse_c (tc_pulse_c),
    .tc_gap_c   (tc_gap_c)
  );

  // Edge detect; with retrigger enabled the active source's rise restarts its pulse instead of queueing.
  always_comb begin
    rise = trigx & ~trig_q;
`ifdef LED_ARB_RETRIG_EN
    retrig   = (state == PULSE) && rise[grant_id];
    rise_eff = retrig ? (rise & ~(NREQ'(1) << grant_id)) : rise;
`else
    rise_eff = rise;
`endif
  end

  // Next-state, grant and timer control.
  always_comb begin
    state_n  = state;
    led_n    = 1'b1;
    busy_n   = 1'b0;
    gid_n    = grant_id;
    last_n   = last_grant;
    clr      = '0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    do_grant = 1'b0;
    any_pend = |pend;
    win      = IW'(rr_pick(MAX_NREQ'(pend), MAX_IW'(last_grant), NREQ));

    case (state)
      IDLE: begin
        tmr_clr = 1'b1;
        if (any_pend) do_grant = 1'b1;
      end
      PULSE: begin
        tmr_en = 1'b1;
`ifdef LED_ARB_RETRIG_EN
        if (retrig) tmr_clr = 1'b1;
        else
`endif
        if (tc_pulse_c) begin
          tmr_clr = 1'b1;
          if (GAP_TIME != 0) state_n = GAP;
          else if (any_pend) do_grant = 1'b1;
          else state_n = IDLE;
        end
      end
      GAP: begin
        tmr_en = 1'b1;
        if (tc_gap_c) begin
          tmr_clr = 1'b1;
          if (any_pend) do_grant = 1'b1;
          else state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_grant) begin
      state_n = PULSE;
      gid_n   = win;
      last_n  = win;
      clr     = NREQ'(1) << win;
      tmr_clr = 1'b1;
    end

    led_n  = (state_n != PULSE);
    busy_n = (state_n != IDLE);
    // A rise in the grant cycle re-queues the bit it just cleared.
    pend_n = (pend & ~clr) | rise_eff;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      led        <= 1'b1;
      busy       <= 1'b0;
      grant_id   <= '0;
      last_grant <= IW'(NREQ - 1);
      pend       <= '0;
      trig_q     <= '0;
    end else begin
      state      <= state_n;
      led        <= led_n;
      busy       <= busy_n;
      grant_id   <= gid_n;
      last_grant <= last_n;
      pend       <= pend_n;
      trig_q     <= trigx;
    end
  end

endmodule

// File: tb/tb_led_pulse_arb.sv
// Bench for led_pulse_arb: two instances (GAP_TIME=3 and GAP_TIME=0) sharing
// stimulus, a per-cycle reference model, a directed vector table and a few
// multi-cycle sequences.
module tb_led_pulse_arb;

  localparam int PULSE = 10;
  localparam int GAP_A = 3;
  localparam int NR    = 4;
  localparam int NI    = 2;

  logic       clk, rst;
  logic [3:0] trigx;
  logic       led_a, busy_a, led_b, busy_b;
  logic [1:0] gid_a, gid_b;
  logic [3:0] pend_a, pend_b;

  int n_cmp = 0;
  int n_bad = 0;

  led_pulse_arb #(.NREQ(NR), .PULSE_TIME(PULSE), .GAP_TIME(GAP_A), .CW(8)) u_dut_a (
    .clk(clk), .rst(rst), .trigx(trigx),
    .led(led_a), .grant_id(gid_a), .busy(busy_a), .pend(pend_a));

  led_pulse_arb #(.NREQ(NR), .PULSE_TIME(PULSE), .GAP_TIME(0), .CW(8)) u_dut_b (
    .clk(clk), .rst(rst), .trigx(trigx),
    .led(led_b), .grant_id(gid_b), .busy(busy_b), .pend(pend_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one elapsed-cycle count per service, lit while e <= PULSE,
  // service complete when e reaches PULSE+gap.
  bit         m_busy [NI];
  int         m_e    [NI];
  int         m_id   [NI];
  int         m_last [NI];
  bit [3:0]   m_pend [NI];
  bit [3:0]   m_prev;

  function automatic int pick(input bit [3:0] p, input int last);
    for (int i = 1; i <= NR; i++) begin
      if (p[(last + i) % NR]) return (last + i) % NR;
    end
    return 0;
  endfunction

  task automatic model_step(input int m, input bit [3:0] rise_in);
    bit [3:0] r, c;
    int gt;
    bit in_pulse;
    r  = rise_in;
    c  = '0;
    gt = (m == 0) ? GAP_A : 0;
    if (rst) begin
      m_busy[m] = 0; m_e[m] = 0; m_id[m] = 0; m_last[m] = NR - 1; m_pend[m] = '0;
      return;
    end
    in_pulse = m_busy[m] && (m_e[m] <= PULSE);
    if (!m_busy[m]) begin
      if (m_pend[m] != 0) begin
        m_id[m] = pick(m_pend[m], m_last[m]); m_last[m] = m_id[m];
        m_e[m] = 0; m_busy[m] = 1; c[m_id[m]] = 1'b1;
      end
    end else begin
`ifdef LED_ARB_RETRIG_EN
      if (in_pulse && r[m_id[m]]) begin
        r[m_id[m]] = 1'b0;
        m_e[m] = 0;
      end else
`endif
      if (m_e[m] == PULSE + gt) begin
        if (m_pend[m] != 0) begin
          m_id[m] = pick(m_pend[m], m_last[m]); m_last[m] = m_id[m];
          m_e[m] = 0; c[m_id[m]] = 1'b1;
        end else begin
          m_busy[m] = 0;
        end
      end else begin
        m_e[m]++;
      end
    end
    if (in_pulse) begin end
    m_pend[m] = (m_pend[m] & ~c) | r;
  endtask

  // Advance the model on every active edge using the same inputs the DUTs see.
  always @(posedge clk) begin : model
    bit [3:0] rise;
    rise   = trigx & ~m_prev;
    m_prev = rst ? 4'b0 : trigx;
    for (int m = 0; m < NI; m++) model_step(m, rise);
  end

  function automatic logic [7:0] pk(input logic l, input logic b, input logic [1:0] g, input logic [3:0] p);
    return {l, b, g, p};
  endfunction

  function automatic logic [7:0] model_pk(input int m);
    return pk(!(m_busy[m] && (m_e[m] <= PULSE)), m_busy[m], 2'(m_id[m]), m_pend[m]);
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got led=%b busy=%b gid=%0d pend=%b, want led=%b busy=%b gid=%0d pend=%b",
               name, act[7], act[6], act[5:4], act[3:0], exp[7], exp[6], exp[5:4], exp[3:0]);
    end
  endtask

  task automatic cmp_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One clock: sample away from the edge and check both instances against the model.
  task automatic step();
    @(posedge clk);
    #1;
    cmp("model_a", pk(led_a, busy_a, gid_a, pend_a), model_pk(0));
    cmp("model_b", pk(led_b, busy_b, gid_b, pend_b), model_pk(1));
  endtask

  typedef struct {
    bit       rst;
    bit [3:0] trig;
    int       n;
    bit [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   order[$];
  int   exp_order[$];
  int   runs, len, first_len, falls;
  logic prev;

  initial begin
    rst   = 1'b1;
    trigx = 4'b0;

    // Single request on source 1.
    vecs.push_back('{1'b1, 4'b0000, 2,  pk(1, 0, 0, 4'b0000)});
    vecs.push_back('{1'b0, 4'b0010, 1,  pk(1, 0, 0, 4'b0010)});
    vecs.push_back('{1'b0, 4'b0000, 1,  pk(0, 1, 1, 4'b0000)});
    vecs.push_back('{1'b0, 4'b0000, 10, pk(0, 1, 1, 4'b0000)});
    vecs.push_back('{1'b0, 4'b0000, 1,  pk(1, 1, 1, 4'b0000)});
    vecs.push_back('{1'b0, 4'b0000, 2,  pk(1, 1, 1, 4'b0000)});
    vecs.push_back('{1'b0, 4'b0000, 1,  pk(1, 0, 1, 4'b0000)});
    // Simultaneous edges on sources 0 and 2.
    vecs.push_back('{1'b1, 4'b0000, 1,  pk(1, 0, 0, 4'b0000)});
    vecs.push_back('{1'b0, 4'b0101, 1,  pk(1, 0, 0, 4'b0101)});
    vecs.push_back('{1'b0, 4'b0000, 1,  pk(0, 1, 0, 4'b0100)});
    vecs.push_back('{1'b0, 4'b0000, 10, pk(0, 1, 0, 4'b0100)});
    vecs.push_back('{1'b0, 4'b0000, 3,  pk(1, 1, 0, 4'b0100)});
    vecs.push_back('{1'b0, 4'b0000, 1,  pk(0, 1, 2, 4'b0000)});
    vecs.push_back('{1'b0, 4'b0000, 11, pk(1, 1, 2, 4'b0000)});
    vecs.push_back('{1'b0, 4'b0000, 3,  pk(1, 0, 2, 4'b0000)});
    // Re-queue: source 1 rises again in the cycle it is granted.
    vecs.push_back('{1'b1, 4'b0000, 1,  pk(1, 0, 0, 4'b0000)});
    vecs.push_back('{1'b0, 4'b0001, 1,  pk(1, 0, 0, 4'b0001)});
    vecs.push_back('{1'b0, 4'b0010, 1,  pk(0, 1, 0, 4'b0010)});
    vecs.push_back('{1'b0, 4'b0000, 13, pk(1, 1, 0, 4'b0010)});
    vecs.push_back('{1'b0, 4'b0010, 1,  pk(0, 1, 1, 4'b0010)});
    vecs.push_back('{1'b0, 4'b0000, 14, pk(0, 1, 1, 4'b0000)});
    vecs.push_back('{1'b0, 4'b0000, 14, pk(1, 0, 1, 4'b0000)});
    // Reset mid-pulse discards queued work; source 0 then has first priority.
    vecs.push_back('{1'b1, 4'b0000, 1,  pk(1, 0, 0, 4'b0000)});
    vecs.push_back('{1'b0, 4'b0100, 1,  pk(1, 0, 0, 4'b0100)});
    vecs.push_back('{1'b0, 4'b0000, 1,  pk(0, 1, 2, 4'b0000)});
    vecs.push_back('{1'b0, 4'b0001, 1,  pk(0, 1, 2, 4'b0001)});
    vecs.push_back('{1'b0, 4'b0000, 4,  pk(0, 1, 2, 4'b0001)});
    vecs.push_back('{1'b1, 4'b0000, 1,  pk(1, 0, 0, 4'b0000)});
    vecs.push_back('{1'b0, 4'b1001, 1,  pk(1, 0, 0, 4'b1001)});
    vecs.push_back('{1'b0, 4'b0000, 1,  pk(0, 1, 0, 4'b1000)});

    foreach (vecs[i]) begin
      rst   = vecs[i].rst;
      trigx = vecs[i].trig;
      repeat (vecs[i].n) step();
      cmp($sformatf("vec%0d", i), pk(led_a, busy_a, gid_a, pend_a), vecs[i].exp);
    end

    // Fairness: all four strobed while source 2 is being served.
    rst = 1'b1; trigx = 4'b0; step(); rst = 1'b0;
    trigx = 4'b0100; step(); trigx = 4'b0; step();
    trigx = 4'b1111; step(); trigx = 4'b0;
    prev = led_a;
    for (int c = 0; c < 200; c++) begin
      step();
      if (prev && !led_a) order.push_back(int'(gid_a));
      prev = led_a;
    end
`ifdef LED_ARB_RETRIG_EN
    exp_order = '{3, 0, 1};
`else
    exp_order = '{3, 0, 1, 2};
`endif
    cmp_int("rr_order_len", order.size(), exp_order.size());
    foreach (exp_order[i]) begin
      if (i < order.size()) cmp_int($sformatf("rr_order%0d", i), order[i], exp_order[i]);
    end

    // A level held high queues exactly one request.
    rst = 1'b1; step(); rst = 1'b0;
    trigx = 4'b0001;
    prev = led_a; falls = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (prev && !led_a) falls++;
      prev = led_a;
    end
    trigx = 4'b0;
    cmp_int("level_pulses", falls, 1);
    cmp_int("level_idle", int'(busy_a), 0);

    // Restrobe of the active source late in its pulse.
    rst = 1'b1; step(); rst = 1'b0;
    trigx = 4'b0010; step(); trigx = 4'b0;
    runs = 0; len = 0; first_len = 0;
    for (int c = 0; c < 80; c++) begin
      trigx = (c == 8) ? 4'b0010 : 4'b0000;
      step();
      if (!led_a) len++;
      else if (len > 0) begin
        runs++;
        if (runs == 1) first_len = len;
        len = 0;
      end
    end
`ifdef LED_ARB_RETRIG_EN
    cmp_int("retrig_runs", runs, 1);
    cmp_int("retrig_len", first_len, 19);
`else
    cmp_int("restrobe_runs", runs, 2);
    cmp_int("restrobe_len", first_len, 11);
`endif

    // Zero gap: two queued requests give one unbroken 22-cycle lit run.
    rst = 1'b1; trigx = 4'b0; step(); rst = 1'b0;
    trigx = 4'b0011; step(); trigx = 4'b0;
    runs = 0; len = 0; first_len = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (!led_b) len++;
      else if (len > 0) begin
        runs++;
        if (runs == 1) first_len = len;
        len = 0;
      end
    end
    cmp_int("gap0_runs", runs, 1);
    cmp_int("gap0_len", first_len, 22);

    // Random traffic with occasional resets, checked every cycle against the model.
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(7) == 0) trigx[b] = ~trigx[b];
      end
      rst = ($urandom_range(499) == 0);
      step();
    end
    rst = 1'b0; trigx = 4'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
